// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared definitions for the fetch-stage program-counter generator.
//   pc_src_e           : which source supplies the next PC in a given cycle
//   *_DEFAULT          : default width, reset vector and increment for pc_gen
//   ALIGN_MASK         : low address bits that must be zero for a legal target
package pc_gen_pkg;

    typedef enum logic [2:0] {
        SRC_TRAP   = 3'd0,
        SRC_BRANCH = 3'd1,
        SRC_RAS    = 3'd2,
        SRC_SEQ    = 3'd3,
        SRC_HOLD   = 3'd4
    } pc_src_e;

    localparam int          XLEN_DEFAULT         = 32;
    localparam int          INC_DEFAULT          = 4;
    localparam logic [63:0] RESET_VECTOR_DEFAULT = 64'h0;
    localparam logic [1:0]  ALIGN_MASK           = 2'b11;

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack with saturating occupancy count.
// A push onto a full stack silently overwrites the oldest entry.
// A simultaneous push and pop replaces the top entry in place.
// Ports:
//   clk, reset     clock, async active-high reset (count cleared, contents discarded)
//   push, pop      qualified push/pop strobes (already gated by the caller)
//   clear          empties the stack; dominates push/pop
//   push_addr      value written on push
//   top            current top entry (undefined when empty)
//   empty          stack holds no entries
module pc_ras #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic            clear,
    input  logic [XLEN-1:0] push_addr,
    output logic [XLEN-1:0] top,
    output logic            empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [XLEN-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] top_ptr;
    logic [PTR_W-1:0] up_ptr;
    logic [PTR_W:0]   count;

    assign up_ptr = top_ptr + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            top_ptr <= '0;
            count   <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (push && !pop) begin
            top_ptr <= up_ptr;
            if (count != (PTR_W+1)'(DEPTH))
                count <= count + 1'b1;
        end else if (pop && !push) begin
            top_ptr <= top_ptr - 1'b1;
            count   <= count - 1'b1;
        end
    end

    // Storage needs no reset: occupancy is tracked solely by count.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            if (pop)
                mem[top_ptr] <= push_addr;
            else
                mem[up_ptr] <= push_addr;
        end
    end

    assign top   = mem[top_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/pc_gen.sv
// pc_gen: parametrised program-counter generator for the fetch stage.
// Next PC is chosen by priority: trap, aligned branch, (misaligned branch ->
// hold + error), RAS pop, sequential increment, hold. Redirects ignore
// stall/fetch_ready; RAS and sequential advance only on an accepted fetch.
// Optional feature macro: PC_GEN_RAS_EN builds the return-address stack;
// without it ras_push/ras_pop are ignored and ras_empty is tied to 1.
// Ports:
//   clk, reset            clock, async active-high reset
//   stall, fetch_ready    hazard hold and instruction-memory ready
//   branch_taken/_addr    execute-stage redirect
//   trap_taken/_vector    trap redirect (vector forced to 4-byte alignment)
//   ras_push/_addr        call seen, push return address
//   ras_pop               return predicted, use RAS top
//   pc_out, pc_valid      fetch request towards instruction memory
//   misalign_err/_addr    one-cycle error pulse and last rejected target
//   ras_empty             RAS holds no entries
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
    parameter int              INC          = INC_DEFAULT,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            fetch_ready,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_addr,
    input  logic            trap_taken,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            ras_push,
    input  logic [XLEN-1:0] ras_push_addr,
    input  logic            ras_pop,
    output logic [XLEN-1:0] pc_out,
    output logic            pc_valid,
    output logic            misalign_err,
    output logic [XLEN-1:0] misalign_addr,
    output logic            ras_empty
);

    localparam logic [XLEN-1:0] ALIGN_MASK_X = {{(XLEN-2){1'b0}}, ALIGN_MASK};

    logic            accept;
    logic            misaligned;
    logic            redirect;
    logic            pop_req;
    logic [XLEN-1:0] ras_top;
    logic [XLEN-1:0] next_pc;
    pc_src_e         src;

    assign accept     = pc_valid & fetch_ready & ~stall;
    assign misaligned = (branch_addr & ALIGN_MASK_X) != '0;
    assign redirect   = trap_taken | branch_taken;

`ifdef PC_GEN_RAS_EN
    logic ras_push_en;
    logic ras_pop_en;

    assign pop_req     = ras_pop;
    // A misaligned branch still counts as a redirect: the stack is left alone.
    assign ras_push_en = accept & ras_push & ~redirect;
    assign ras_pop_en  = accept & ras_pop & ~ras_empty & ~redirect;

    pc_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push_en),
        .pop       (ras_pop_en),
        .clear     (trap_taken),
        .push_addr (ras_push_addr),
        .top       (ras_top),
        .empty     (ras_empty)
    );
`else
    logic unused_ras;

    assign pop_req    = 1'b0;
    assign ras_top    = '0;
    assign ras_empty  = 1'b1;
    assign unused_ras = ^{ras_push, ras_pop, ras_push_addr};
`endif

    always_comb begin
        src = SRC_HOLD;
        if (trap_taken)
            src = SRC_TRAP;
        else if (branch_taken)
            src = misaligned ? SRC_HOLD : SRC_BRANCH;
        else if (accept && pop_req && !ras_empty)
            src = SRC_RAS;
        else if (accept)
            src = SRC_SEQ;
    end

    always_comb begin
        next_pc = pc_out;
        case (src)
            SRC_TRAP:   next_pc = trap_vector & ~ALIGN_MASK_X;
            SRC_BRANCH: next_pc = branch_addr;
            SRC_RAS:    next_pc = ras_top;
            SRC_SEQ:    next_pc = pc_out + XLEN'(INC);
            default:    next_pc = pc_out;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_out        <= RESET_VECTOR;
            pc_valid      <= 1'b0;
            misalign_err  <= 1'b0;
            misalign_addr <= '0;
        end else begin
            pc_out       <= next_pc;
            pc_valid     <= 1'b1;
            misalign_err <= ~trap_taken & branch_taken & misaligned;
            if (~trap_taken & branch_taken & misaligned)
                misalign_addr <= branch_addr;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        fetch_ready;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        trap_taken;
    logic [31:0] trap_vector;
    logic        ras_push;
    logic [31:0] ras_push_addr;
    logic        ras_pop;
    logic [31:0] pc_out;
    logic        pc_valid;
    logic        misalign_err;
    logic [31:0] misalign_addr;
    logic        ras_empty;

    always #5 clk = ~clk;

    pc_gen #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0),
        .INC          (4),
        .RAS_DEPTH    (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .fetch_ready   (fetch_ready),
        .branch_taken  (branch_taken),
        .branch_addr   (branch_addr),
        .trap_taken    (trap_taken),
        .trap_vector   (trap_vector),
        .ras_push      (ras_push),
        .ras_push_addr (ras_push_addr),
        .ras_pop       (ras_pop),
        .pc_out        (pc_out),
        .pc_valid      (pc_valid),
        .misalign_err  (misalign_err),
        .misalign_addr (misalign_addr),
        .ras_empty     (ras_empty)
    );

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic        err;
        logic [31:0] eaddr;
        logic        empty;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state: the RAS is a plain queue, newest entry at the back.
    logic [31:0] m_pc;
    logic        m_valid;
    logic        m_err;
    logic [31:0] m_eaddr;
    logic [31:0] m_ras[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic model_empty();
`ifdef PC_GEN_RAS_EN
        return m_ras.size() == 0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_step();
        logic acc;
        acc = m_valid && fetch_ready && !stall;
        if (reset) begin
            m_pc = 32'h0; m_valid = 0; m_err = 0; m_eaddr = 32'h0;
            m_ras.delete();
        end else begin
            m_err = 0;
            if (trap_taken) begin
                m_pc = (trap_vector / 4) * 4;
                m_ras.delete();
            end else if (branch_taken && (branch_addr % 4) != 0) begin
                m_err   = 1;
                m_eaddr = branch_addr;
            end else if (branch_taken) begin
                m_pc = branch_addr;
            end else if (acc) begin
`ifdef PC_GEN_RAS_EN
                if (ras_pop && m_ras.size() > 0) begin
                    m_pc = m_ras[$];
                    void'(m_ras.pop_back());
                end else begin
                    m_pc = m_pc + 32'd4;
                end
                if (ras_push) begin
                    if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
                    m_ras.push_back(ras_push_addr);
                end
`else
                m_pc = m_pc + 32'd4;
`endif
            end
            m_valid = 1;
        end
    endtask

    // One cycle: inputs are already set (at a negedge); predict the state
    // after the coming posedge, queue it, move on to the next negedge.
    task automatic tick();
        exp_t e;
        model_step();
        e.pc = m_pc; e.valid = m_valid; e.err = m_err; e.eaddr = m_eaddr;
        e.empty = model_empty();
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle();
        stall = 0; branch_taken = 0; trap_taken = 0; ras_push = 0; ras_pop = 0;
    endtask

    // Monitor: compare DUT outputs shortly after each active edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc_out", pc_out, e.pc);
                chk("pc_valid", 32'(pc_valid), 32'(e.valid));
                chk("misalign_err", 32'(misalign_err), 32'(e.err));
                chk("misalign_addr", misalign_addr, e.eaddr);
                chk("ras_empty", 32'(ras_empty), 32'(e.empty));
            end
        end
    end

    initial begin
        reset = 1; fetch_ready = 0; branch_addr = 0; trap_vector = 0; ras_push_addr = 0;
        idle();
        m_pc = 0; m_valid = 0; m_err = 0; m_eaddr = 0;
        #1;
        chk("reset_pc_out", pc_out, 32'h0);
        chk("reset_pc_valid", 32'(pc_valid), 32'h0);
        chk("reset_ras_empty", 32'(ras_empty), 32'h1);
        @(negedge clk);
        tick(); tick();

        // Release: valid rises, then 0x4, 0x8, 0xC, 0x10.
        reset = 0; fetch_ready = 1;
        repeat (5) tick();
        stall = 1; repeat (3) tick();
        stall = 0; tick();

        // Redirect ignores fetch_ready.
        fetch_ready = 0; branch_taken = 1; branch_addr = 32'h100; tick();
        branch_taken = 0; tick();
        fetch_ready = 1;

        // Misaligned target: hold plus error pulse.
        branch_taken = 1; branch_addr = 32'h102; tick();
        branch_taken = 0; tick(); tick();

        // RAS overflow then drain, then pop on empty.
        ras_push = 1;
        for (int i = 0; i < 5; i++) begin
            ras_push_addr = 32'hA0 + 32'(i) * 32'h10;
            tick();
        end
        ras_push = 0; ras_pop = 1;
        repeat (6) tick();
        ras_pop = 0;

        // Trap beats branch, clears RAS.
        ras_push = 1; ras_push_addr = 32'h300; tick();
        ras_push = 0;
        trap_taken = 1; trap_vector = 32'h203; branch_taken = 1; branch_addr = 32'h40; tick();
        trap_taken = 0; branch_taken = 0; ras_pop = 1; tick();
        ras_pop = 0;

        // Push and pop together.
        ras_push = 1; ras_push_addr = 32'h500; tick();
        ras_pop = 1; ras_push_addr = 32'h600; tick();
        ras_push = 0; tick();
        ras_pop = 0;

        // Wrap at the top of the address space.
        branch_taken = 1; branch_addr = 32'hFFFF_FFFC; tick();
        branch_taken = 0; tick(); tick();

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            reset         = ($urandom_range(99) == 0);
            stall         = ($urandom_range(3) == 0);
            fetch_ready   = ($urandom_range(3) != 0);
            branch_taken  = ($urandom_range(9) == 0);
            branch_addr   = ($urandom & 32'hFFFF_FFFC) |
                            (($urandom_range(3) == 0) ? 32'($urandom_range(3)) : 32'h0);
            trap_taken    = ($urandom_range(29) == 0);
            trap_vector   = $urandom;
            ras_push      = ($urandom_range(2) == 0);
            ras_push_addr = $urandom & 32'hFFFF_FFFC;
            ras_pop       = ($urandom_range(2) == 0);
            tick();
        end
        reset = 0; idle();
        tick(); tick();

        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() == 0)
            n_pass++;
        else
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch stage. It replaces the fixed 32-bit, reset-to-zero PC with a unit that has:
- configurable width, reset vector and increment;
- prioritised trap and branch redirects with misalignment checking;
- a valid/ready handshake towards instruction memory;
- an optional return-address stack (RAS) for return prediction.

It sits between the hazard/execute/trap logic and the instruction-memory port.

## Interface
Parameters
- XLEN, 32, address width
- RESET_VECTOR, 0, PC value after reset
- INC, 4, sequential increment in bytes
- RAS_DEPTH, 4, RAS entries (power of two, ≥2)

Ports
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-high
- stall  in  1  hazard-unit hold of sequential/predicted advance
- fetch_ready  in  1  instruction memory accepts pc_out this cycle
- branch_taken  in  1  execute-stage redirect request
- branch_addr  in  XLEN  branch/jump target
- trap_taken  in  1  trap redirect request
- trap_vector  in  XLEN  trap handler base
- ras_push  in  1  call seen; push ras_push_addr
- ras_push_addr  in  XLEN  return address of the call
- ras_pop  in  1  return predicted; use RAS top as next PC
- pc_out  out  XLEN  current fetch address
- pc_valid  out  1  pc_out is a valid fetch request
- misalign_err  out  1  one-cycle pulse: rejected misaligned branch target
- misalign_addr  out  XLEN  last rejected target, held until next error
- ras_empty  out  1  RAS holds no entries

## Operation
- Accept = pc_valid & fetch_ready & !stall.
- Next-PC priority, evaluated every cycle:
  1. trap_taken → {trap_vector[XLEN-1:2], 2'b00}
  2. branch_taken, target aligned → branch_addr
  3. branch_taken, target misaligned (branch_addr[1:0] != 0) → PC holds; misalign_err=1 next cycle; misalign_addr ← branch_addr
  4. accept & ras_pop & !ras_empty → RAS top (popped)
  5. accept → pc_out + INC (mod 2^XLEN; wraps silently)
  6. otherwise hold.
- Redirects (1, 2) ignore stall and fetch_ready; they are flushes. The memory side abandons any unaccepted request.
- ras_pop with RAS empty → treated as sequential (rule 5); no pop occurs.
- RAS push/pop take effect only when accepted (push additionally requires no trap/branch that cycle).
- RAS full + push → oldest entry overwritten (circular); count saturates at RAS_DEPTH.
- Push and pop in the same accepted cycle → next PC = old top; ras_push_addr becomes the new top; count unchanged.
- Branch redirects do not modify the RAS. A trap clears it (count=0).

## Timing
- Reset (asynchronous) values:
  - pc_out=RESET_VECTOR, pc_valid=0, misalign_err=0, misalign_addr=0, ras_empty=1, RAS count=0.
- First clock edge after reset deassertion: pc_valid→1. pc_out stays RESET_VECTOR until first accept.
- Latency:
  - All next-PC updates appear on pc_out one cycle after the decision edge.
  - No combinational path from inputs to pc_out or pc_valid.
- Handshake: while pc_valid & !fetch_ready, pc_out is stable unless a redirect occurs.
- Reset asserted mid-operation: immediate return to reset values, independent of clk. RAS contents are discarded.

## Configuration
- Macro PC_GEN_RAS_EN.
- Defined:
  - RAS and all rules above are built.
- Undefined:
  - ras_push and ras_pop are ignored.
  - ras_empty is constant 1.
  - No RAS storage is synthesised.
  - Ports remain for a uniform interface.

## Structure
- Shared package pc_gen_pkg holds:
  - redirect-source enum (TRAP, BRANCH, RAS, SEQ, HOLD);
  - default XLEN/INC/RESET_VECTOR constants;
  - alignment mask constant.
- One sub-module, pc_ras:
  - circular stack with top pointer and saturating count;
  - push/pop/clear inputs; top and empty outputs.
- pc_gen instantiates pc_ras under PC_GEN_RAS_EN.

## Test plan
- Reset release, fetch_ready=1, no stall:
  - pc_out 0x0, 0x4, 0x8 on successive cycles;
  - pc_valid low until the first edge after release.
- stall=1 for 3 cycles at pc 0x10: pc_out holds 0x10; resumes 0x14.
- fetch_ready=0 while branch_taken=1, branch_addr=0x100 → pc_out=0x100 next cycle.
- trap_taken=1, trap_vector=0x203, with branch_taken=1, branch_addr=0x40 → pc_out=0x200; RAS emptied.
- branch_addr=0x102:
  - pc holds;
  - misalign_err pulses one cycle;
  - misalign_addr=0x102.
- RAS_DEPTH=4 (macro on):
  - push 0xA0, 0xB0, 0xC0, 0xD0, 0xE0, then pop ×5;
  - next PCs 0xE0, 0xD0, 0xC0, 0xB0, then sequential;
  - ras_empty=1 after the 4th pop;
  - pop with RAS empty falls back to pc+4.
